// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: connection between trap_ctrl and csr_file.
//   getCsr_addr  read address into csr_file
//   putCsr_addr  write address into csr_file
//   useCsr       write enable (csr_file writes on the negedge)
//   result       write data
//   csr          combinational read data from csr_file
//   mie          mstatus.MIE as seen by csr_file
//   mtvec_val    current mtvec contents
// master = trap_ctrl side, slave = csr_file side.
interface trap_ctrl_if #(
    parameter int W = 32,
    parameter int R = 3
);
    logic [R-1:0] getCsr_addr;
    logic [R-1:0] putCsr_addr;
    logic         useCsr;
    logic [W-1:0] result;
    logic [W-1:0] csr;
    logic         mie;
    logic [W-1:0] mtvec_val;

    modport master (
        output getCsr_addr, putCsr_addr, useCsr, result,
        input  csr, mie, mtvec_val
    );

    modport slave (
        input  getCsr_addr, putCsr_addr, useCsr, result,
        output csr, mie, mtvec_val
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer in front of csr_file.
// Accepts a synchronous exception, level interrupts or mret, sequences the
// MEPC / MCAUSE / MSTATUS writes through csr_file's single write port, then
// redirects the PC. The pipeline is stalled for the whole sequence.
// Ports:
//   clk, a_reset_n        clock, async active-low reset
//   irq                   level interrupt requests (lowest index wins)
//   exc_valid, exc_code   exception pulse and its cause code
//   mret                  mret pulse
//   epc                   PC to save in MEPC
//   csr_bus               csr_file read/write port (master side)
//   stall                 high in every non-IDLE state
//   pc_load, trap_pc      one-cycle PC redirect and its target
//   trap_ack              one-cycle pulse in the cycle after trap acceptance
//
// state    | meaning
// IDLE     | waiting; evaluates exc_valid > irq (if mie) > mret
// T_EPC    | write MEPC with latched epc, trap_ack high
// T_CAUSE  | write MCAUSE with latched cause
// T_STATUS | write MSTATUS (MPIE<=MIE, MIE<=0), register the jump target
// T_JUMP   | redirect PC to the trap vector
// R_STATUS | write MSTATUS (MIE<=MPIE, MPIE<=1)
// R_JUMP   | redirect PC to MEPC
module trap_ctrl #(
    parameter int W             = 32,
    parameter int R             = 3,
    parameter int NUM_IRQ       = 4,
    parameter int IRQ_CODE_BASE = 16
) (
    input  logic               clk,
    input  logic               a_reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               exc_valid,
    input  logic [3:0]         exc_code,
    input  logic               mret,
    input  logic [W-1:0]       epc,
    trap_ctrl_if.master        csr_bus,
    output logic               stall,
    output logic               pc_load,
    output logic [W-1:0]       trap_pc,
    output logic               trap_ack
);
    localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [R-1:0] A_MSTATUS = R'(0);
    localparam logic [R-1:0] A_MEPC    = R'(3);
    localparam logic [R-1:0] A_MCAUSE  = R'(4);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_STATUS = 3'd3,
        T_JUMP   = 3'd4,
        R_STATUS = 3'd5,
        R_JUMP   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cause_q, cause_d;
    logic [W-1:0]   epc_q, epc_d;
    logic [W-1:0]   target_q, target_d;
    logic           is_int_q, is_int_d;

    logic           irq_hit;
    logic [IDXW-1:0] irq_idx;
    logic [W-2:0]   irq_code;
    logic [W-1:0]   base;
    logic [W-1:0]   vec_off;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq[k]) begin
                irq_hit = 1'b1;
                irq_idx = k[IDXW-1:0];
            end
        end
    end

    assign irq_code = (W-1)'(IRQ_CODE_BASE) + (W-1)'(irq_idx);
    assign base     = {csr_bus.mtvec_val[W-1:2], 2'b00};
    // 4*code modulo 2^W: the top bit of the code shifts out.
    assign vec_off  = {cause_q[W-3:0], 2'b00};

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            target_q <= '0;
            is_int_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            target_q <= target_d;
            is_int_q <= is_int_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cause_d             = cause_q;
        epc_d               = epc_q;
        target_d            = target_q;
        is_int_d            = is_int_q;
        csr_bus.getCsr_addr = A_MSTATUS;
        csr_bus.putCsr_addr = '0;
        csr_bus.useCsr      = 1'b0;
        csr_bus.result      = '0;
        stall               = 1'b1;
        pc_load             = 1'b0;
        trap_pc             = '0;
        trap_ack            = 1'b0;

        case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (exc_valid) begin
                    cause_d  = W'(exc_code);
                    is_int_d = 1'b0;
                    epc_d    = epc;
                    state_d  = T_EPC;
                end else if (csr_bus.mie && irq_hit) begin
                    cause_d  = {1'b1, irq_code};
                    is_int_d = 1'b1;
                    epc_d    = epc;
                    state_d  = T_EPC;
                end else if (mret) begin
                    state_d  = R_STATUS;
                end
            end
            T_EPC: begin
                trap_ack            = 1'b1;
                csr_bus.useCsr      = 1'b1;
                csr_bus.putCsr_addr = A_MEPC;
                csr_bus.result      = epc_q;
                state_d             = T_CAUSE;
            end
            T_CAUSE: begin
                csr_bus.useCsr      = 1'b1;
                csr_bus.putCsr_addr = A_MCAUSE;
                csr_bus.result      = cause_q;
                state_d             = T_STATUS;
            end
            T_STATUS: begin
                csr_bus.useCsr      = 1'b1;
                csr_bus.putCsr_addr = A_MSTATUS;
                csr_bus.result      = csr_bus.csr;
                csr_bus.result[7]   = csr_bus.csr[3];
                csr_bus.result[3]   = 1'b0;
                // Vectored only for interrupts in mode 01; modes 10/11 act as direct.
                if (csr_bus.mtvec_val[1:0] == 2'b01 && is_int_q)
                    target_d = base + vec_off;
                else
                    target_d = base;
                state_d = T_JUMP;
            end
            T_JUMP: begin
                pc_load = 1'b1;
                trap_pc = target_q;
                state_d = IDLE;
            end
            R_STATUS: begin
                csr_bus.useCsr      = 1'b1;
                csr_bus.putCsr_addr = A_MSTATUS;
                csr_bus.result      = csr_bus.csr;
                csr_bus.result[3]   = csr_bus.csr[7];
                csr_bus.result[7]   = 1'b1;
                state_d             = R_JUMP;
            end
            R_JUMP: begin
                csr_bus.getCsr_addr = A_MEPC;
                pc_load             = 1'b1;
                trap_pc             = csr_bus.csr;
                state_d             = IDLE;
            end
            default: begin
                stall   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl with a small csr_file model.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset_n;
    logic [3:0]  irq;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic        mret;
    logic [31:0] epc;
    logic        stall, pc_load, trap_ack;
    logic [31:0] trap_pc;

    trap_ctrl_if #(.W(32), .R(3)) bus ();

    trap_ctrl #(.W(32), .R(3), .NUM_IRQ(4), .IRQ_CODE_BASE(16)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .irq       (irq),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .mret      (mret),
        .epc       (epc),
        .csr_bus   (bus),
        .stall     (stall),
        .pc_load   (pc_load),
        .trap_pc   (trap_pc),
        .trap_ack  (trap_ack)
    );

    // csr_file model: writes on negedge, async reset to init values.
    logic [31:0] mem [0:7];
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [31:0] pl_data;

    function automatic logic [31:0] csr_init(int i);
        return (i == 1) ? 32'h4000_0100 : 32'h0;
    endfunction

    always @(negedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= csr_init(i);
        end else if (bus.useCsr) begin
            mem[bus.putCsr_addr] <= bus.result;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    assign bus.csr       = mem[bus.getCsr_addr];
    assign bus.mie       = mem[0][3];
    assign bus.mtvec_val = mem[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},   32'(stall), 0);
        chk({tag, "_pcload"},  32'(pc_load), 0);
        chk({tag, "_usecsr"},  32'(bus.useCsr), 0);
        chk({tag, "_ack"},     32'(trap_ack), 0);
    endtask

    task automatic run_trap(input string tag, input logic [31:0] e_epc, input logic [31:0] e_cause,
                            input logic [31:0] e_status, input logic [31:0] e_pc);
        for (int i = 0; i < 12; i++) begin
            step();
            if (trap_ack) break;
        end
        chk({tag, "_ack"}, 32'(trap_ack), 1);
        exc_valid = 1'b0;
        irq       = 4'b0;
        chk({tag, "_epc_stall"}, 32'(stall), 1);
        chk({tag, "_epc_we"},    32'(bus.useCsr), 1);
        chk({tag, "_epc_addr"},  32'(bus.putCsr_addr), 3);
        chk({tag, "_epc_data"},  bus.result, e_epc);
        step();
        chk({tag, "_cause_addr"}, 32'(bus.putCsr_addr), 4);
        chk({tag, "_cause_data"}, bus.result, e_cause);
        chk({tag, "_cause_ack"},  32'(trap_ack), 0);
        step();
        chk({tag, "_st_addr"},   32'(bus.putCsr_addr), 0);
        chk({tag, "_st_data"},   bus.result, e_status);
        chk({tag, "_st_pcload"}, 32'(pc_load), 0);
        step();
        chk({tag, "_jmp_pcload"}, 32'(pc_load), 1);
        chk({tag, "_jmp_pc"},     trap_pc, e_pc);
        chk({tag, "_jmp_stall"},  32'(stall), 1);
        chk({tag, "_jmp_we"},     32'(bus.useCsr), 0);
        step();
        chk_quiet({tag, "_done"});
        chk({tag, "_mepc"},    mem[3], e_epc);
        chk({tag, "_mcause"},  mem[4], e_cause);
        chk({tag, "_mstatus"}, mem[0], e_status);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_reset_n = 1'b0;
        irq       = 4'hF;
        exc_valid = 1'b1;
        exc_code  = 4'd0;
        mret      = 1'b0;
        epc       = 32'h0;
        pl_en     = 1'b0;
        pl_addr   = 3'd0;
        pl_data   = 32'h0;

        // Reset holds everything quiet despite active requests.
        #1;
        chk_quiet("rst0");
        step();
        step();
        chk_quiet("rst1");
        chk("rst_getaddr", 32'(bus.getCsr_addr), 0);
        chk("rst_putaddr", 32'(bus.putCsr_addr), 0);
        chk("rst_result",  bus.result, 0);
        chk("rst_trappc",  trap_pc, 0);
        exc_valid = 1'b0;
        a_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_we",    32'(bus.useCsr), 0);
            chk("post_rst_stall", 32'(stall), 0);
        end
        irq = 4'b0;

        // Vectored interrupt on irq[2]: code 18, target 4*18.
        preload(3'd0, 32'h0000_1808);
        preload(3'd2, 32'h0000_0001);
        irq = 4'b0100;
        epc = 32'h200;
        run_trap("irq2", 32'h200, 32'h8000_0012, 32'h0000_1880, 32'h48);

        // Exception beats a simultaneous interrupt; exceptions never vector.
        preload(3'd0, 32'h0000_1808);
        preload(3'd2, 32'h0000_0101);
        exc_valid = 1'b1;
        exc_code  = 4'd2;
        irq       = 4'b0001;
        epc       = 32'h80;
        run_trap("exc", 32'h80, 32'h2, 32'h0000_1880, 32'h100);

        // mret: MIE restored from MPIE, jump to MEPC two cycles later.
        preload(3'd0, 32'h0000_1880);
        preload(3'd3, 32'h0000_0200);
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("mret_st_we",     32'(bus.useCsr), 1);
        chk("mret_st_addr",   32'(bus.putCsr_addr), 0);
        chk("mret_st_data",   bus.result, 32'h0000_1888);
        chk("mret_st_stall",  32'(stall), 1);
        chk("mret_st_pcload", 32'(pc_load), 0);
        step();
        chk("mret_jmp_pcload", 32'(pc_load), 1);
        chk("mret_jmp_pc",     trap_pc, 32'h200);
        chk("mret_jmp_we",     32'(bus.useCsr), 0);
        step();
        chk_quiet("mret_done");
        chk("mret_mstatus", mem[0], 32'h0000_1888);

        // Masked interrupt stays pending until MIE is set.
        preload(3'd0, 32'h0000_1800);
        preload(3'd2, 32'h0000_0001);
        irq = 4'b1000;
        epc = 32'h300;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("masked_stall", 32'(stall), 0);
            chk("masked_ack",   32'(trap_ack), 0);
        end
        preload(3'd0, 32'h0000_1808);
        run_trap("irq3", 32'h300, 32'h8000_0013, 32'h0000_1880, 32'h4C);

        // Reset while writing MCAUSE aborts the sequence.
        exc_valid = 1'b1;
        exc_code  = 4'd5;
        epc       = 32'h40;
        step();
        exc_valid = 1'b0;
        chk("abort_ack", 32'(trap_ack), 1);
        step();
        chk("abort_cause_we",   32'(bus.useCsr), 1);
        chk("abort_cause_addr", 32'(bus.putCsr_addr), 4);
        a_reset_n = 1'b0;
        #1;
        chk_quiet("abort_rst");
        chk("abort_result", bus.result, 0);
        chk("abort_putaddr", 32'(bus.putCsr_addr), 0);
        chk("abort_mepc",   mem[3], 32'h0);
        chk("abort_mstatus", mem[0], 32'h0);
        step();
        chk("abort_hold_pcload", 32'(pc_load), 0);
        a_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_after_pcload", 32'(pc_load), 0);
            chk("abort_after_we",     32'(bus.useCsr), 0);
        end
        chk("abort_mcause", mem[4], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting directly upstream of csr_file; the sole writer of csr_file's write port during traps and returns.
- Accepts one synchronous exception, external interrupt lines and mret from the core. Sequences the MEPC/MCAUSE/MSTATUS updates through csr_file's single write port, then redirects the PC.
- Stalls the pipeline for the whole sequence.

Parameters:
- W, 32, datapath width.
- R, 3, CSR map address width; matches csr_file.
- NUM_IRQ, 4, number of external interrupt lines.
- IRQ_CODE_BASE, 16, mcause exception code assigned to irq[0]; irq[k] gets IRQ_CODE_BASE+k.

Ports:
- clk  in  1  core clock; this block updates on posedge, csr_file writes on the following negedge.
- a_reset_n  in  1  reset, asynchronous, active-low.
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- exc_valid  in  1  synchronous exception request, one-cycle pulse.
- exc_code  in  4  exception cause code.
- mret  in  1  mret executed, one-cycle pulse.
- epc  in  W  PC to save: the faulting instruction for exceptions, the next instruction for interrupts.
- mie  in  1  from csr_file (mstatus[3]).
- mtvec_val  in  W  from csr_file.
- csr  in  W  csr_file combinational read data.
- getCsr_addr  out  R  csr_file read address.
- putCsr_addr  out  R  csr_file write address.
- useCsr  out  1  csr_file write enable.
- result  out  W  csr_file write data.
- stall  out  1  freeze fetch/decode while high.
- pc_load  out  1  one-cycle PC redirect strobe.
- trap_pc  out  W  redirect target, valid with pc_load.
- trap_ack  out  1  one-cycle pulse on trap acceptance.

Behaviour:
- CSR map: 0 MSTATUS, 1 MISA, 2 MTVEC, 3 MEPC, 4 MCAUSE.
- MSTATUS bits: MIE = bit3, MPIE = bit7, MPP = [12:11] (never modified here).
- All outputs are decoded from state plus latched registers; no output is combinational from irq/exc_valid/mret.
- Reset (async): state=IDLE; latched cause, epc and target cleared. All outputs 0, except getCsr_addr=0.
- FSM states: IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
- IDLE acceptance priority, evaluated at posedge:
  - exc_valid: latch cause={28'b0,exc_code}, is_int=0.
  - else mie=1 and |irq: latch the lowest set index k, cause={1'b1, (IRQ_CODE_BASE+k) in 31 bits}, is_int=1.
  - else mret: go to R_STATUS.
  - On trap acceptance: latch epc, assert trap_ack in the next cycle (T_EPC), go to T_EPC.
- Simultaneous inputs: exc_valid beats irq and mret; irq beats mret. The losing mret is dropped; the core must reissue it.
- irq is ignored outside IDLE and when mie=0; no pending latch.
- exc_valid/mret arriving outside IDLE are ignored; the core guarantees this cannot happen while stall=1.
- T_EPC: useCsr=1, putCsr_addr=3, result=latched epc → T_CAUSE.
- T_CAUSE: useCsr=1, putCsr_addr=4, result=latched cause → T_STATUS.
- T_STATUS: getCsr_addr=0, useCsr=1, putCsr_addr=0.
  - result=csr with bit7=csr[3], bit3=0; all other bits unchanged.
  - Register the target here, then → T_JUMP.
- Target computation:
  - base={mtvec_val[W-1:2],2'b00}.
  - If mtvec_val[1:0]==2'b01 and is_int: target = base + 4*code (code = cause[30:0]), modulo 2^W.
  - Otherwise (mode 00, or any exception): target = base.
  - Mode values 10/11 are treated as 00.
- T_JUMP: pc_load=1, trap_pc=target → IDLE.
- R_STATUS: getCsr_addr=0, useCsr=1, putCsr_addr=0, result=csr with bit3=csr[7], bit7=1 → R_JUMP.
- R_JUMP: getCsr_addr=3, pc_load=1, trap_pc=csr (MEPC, combinational) → IDLE.
- stall=1 in every state except IDLE.
- Latency: trap = 4 cycles after acceptance (pc_load in 4th); mret = 2 cycles.
- Back-to-back: a new trap can be accepted in the IDLE cycle right after T_JUMP or R_JUMP.
  - After a trap, mie=0, so irq cannot re-enter until software or mret restores MIE.
- Reset mid-sequence: abort immediately to IDLE with outputs cleared. A csr_file write already launched on the preceding negedge is overridden by csr_file's own reset.
- Unused states decode to IDLE.

Test Plan:
- Reset with irq=4'hF, exc_valid=1 → all outputs 0, stall=0; no useCsr for 5 cycles after release while mie=0 and no exc/mret.
- mstatus=0x1808, mtvec=0x00000001, irq=4'b0100, epc=0x200 → csr_file ends with MEPC=0x200, MCAUSE=0x80000012, MSTATUS=0x1880. pc_load=1 with trap_pc=0x48 in cycle 4; stall high for 4 cycles.
- exc_valid with exc_code=2, irq=4'b0001, mie=1, same cycle, mtvec=0x101, epc=0x80 → MCAUSE=0x2, trap_pc=0x100; irq ignored.
- After the previous trap (MSTATUS=0x1880, MEPC=0x200), mret → MSTATUS=0x1888, pc_load with trap_pc=0x200 in cycle 2.
- irq=4'b1000 with mie=0 → no trap for 10 cycles. Set mie=1 → trap with MCAUSE=0x80000013 and trap_pc=0x4C (mtvec=0x1).
- Assert a_reset_n=0 during T_CAUSE → outputs 0 immediately, state IDLE, csr_file back to init values, no pc_load.
